scan_reg_n: RTL

- n-bit scan register built from the scan flip-flop cell behaviour: parallel capture, serial scan shift, asynchronous clear and preset.
- Adds a self-timed shift sequencer: one start pulse shifts the whole chain by exactly n bits, with a busy/done handshake.
- Used as the test-access register stage in netlist-generated circuits for serial fault simulation; instances chain through So -> Si.

---
 rtl/scan_reg_n_if.sv | 36 +++
 rtl/scan_reg_n.sv | 127 ++++++++++++
 2 files changed

// File: rtl/scan_reg_n_if.sv
// scan_reg_n_if: data, scan and sequencer handshake bundle for scan_reg_n.
//   D      parallel capture data (N bits)
//   CE     capture enable
//   NbarT  0 = normal, 1 = manual scan shift
//   Si     scan serial in
//   start  request an automatic N-bit shift
//   Q      register state
//   So     scan serial out (Q[N-1])
//   Qo     observed/update output
//   busy   automatic shift in progress
//   done   one-cycle completion pulse
// Modports: slave = the register, master = whoever drives it.
interface scan_reg_n_if #(
  parameter int N = 8
);
  logic [N-1:0] D;
  logic         CE;
  logic         NbarT;
  logic         Si;
  logic         start;
  logic [N-1:0] Q;
  logic         So;
  logic [N-1:0] Qo;
  logic         busy;
  logic         done;

  modport slave (
    input  D, CE, NbarT, Si, start,
    output Q, So, Qo, busy, done
  );

  modport master (
    output D, CE, NbarT, Si, start,
    input  Q, So, Qo, busy, done
  );
endinterface

// File: rtl/scan_reg_n.sv
// scan_reg_n: n-bit scan register with parallel capture, manual scan shift,
// async clear/preset, and a self-timed sequencer that shifts the whole chain
// by exactly n bits per start pulse.
//
// Ports:
//   i_C    clock, rising edge
//   i_CLR  async clear, active-high (clears Q, sequencer, done, shadow)
//   i_PRE  async preset, active-high (Q = all ones, sequencer idle)
//   bus    scan_reg_n_if.slave (D, CE, NbarT, Si, start / Q, So, Qo, busy, done)
//
// Optional build macro SCAN_SHADOW_EN: when defined, Qo comes from a shadow
// register that captures Q on the edge after done; otherwise Qo = Q.
//
// tplh/tphl are simulation-only output delays. This model updates outputs at
// the clock/async event with zero delay, which matches their default of 0.
//
// Sequencer states:
//   state    | meaning
//   ST_IDLE  | busy=0, normal priority (NbarT shift > CE capture > hold)
//   ST_SHIFT | busy=1, one shift per edge, r_cnt counts shifts done so far
module scan_reg_n #(
  parameter int n    = 8,
  parameter int tplh = 0,
  parameter int tphl = 0
) (
  input  logic        i_C,
  input  logic        i_CLR,
  input  logic        i_PRE,
  scan_reg_n_if.slave bus
);

  if (n < 2) begin : g_bad_n
    $error("scan_reg_n: n must be >= 2");
  end
  if (tplh < 0 || tphl < 0) begin : g_bad_delay
    $error("scan_reg_n: tplh/tphl must be non-negative");
  end

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [n-1:0]    r_q;
  logic [n-1:0]    w_shift;

  assign w_shift = {r_q[n-2:0], bus.Si};

  // CLR outranks PRE; with either held, clock edges fall into the async
  // branches and so have no effect.
  always_ff @(posedge i_C or posedge i_CLR or posedge i_PRE) begin
    if (i_CLR) begin
      r_q     <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_PRE) begin
      r_q     <= '1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The start edge itself does not shift; normal priority applies.
          if (bus.NbarT) begin
            r_q <= w_shift;
          end else if (bus.CE) begin
            r_q <= bus.D;
          end
          if (bus.start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_q <= w_shift;
          if (r_cnt == LAST) begin
            r_done <= 1'b1;
            r_cnt  <= '0;
            // start on the completing edge chains straight into a new run.
            if (!bus.start) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.So   = r_q[n-1];
  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = r_done;

`ifdef SCAN_SHADOW_EN
  logic [n-1:0] r_u;

  // Loads on the edge where done is seen high, so it holds the final
  // shifted value. PRE leaves it alone and blocks the load while held.
  always_ff @(posedge i_C or posedge i_CLR) begin
    if (i_CLR) begin
      r_u <= '0;
    end else if (r_done && !i_PRE) begin
      r_u <= r_q;
    end
  end

  assign bus.Qo = r_u;
`else
  assign bus.Qo = r_q;
`endif

endmodule
